// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin packet arbiter merging requester streams onto one UART transmit stream
//
// Purpose:
//   NUM_REQ requesters each offer a byte stream with packet framing (tlast).
//   One requester at a time owns the UART stream for a whole packet.
//   The owner is picked round-robin in IDLE, starting after the previous owner.
//   In DATA the owner's stream is passed through combinationally.
//   A stalled packet is force-released after TIMEOUT consecutive owner-idle cycles.
//
// Optional feature (macro ARB_ID_EN):
//   Each packet is preceded by one header byte carrying the owner index.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req_tdata    NUM_REQ packed bytes; requester i at [i*data_bits +: data_bits]
//   req_tvalid   per-requester byte valid
//   req_tlast    per-requester last byte of packet
//   req_tready   per-requester byte accepted
//   m_tdata      byte to UART data_in
//   m_tvalid     UART data_in_valid
//   m_tready     UART data_in_ready
//   grant        one-hot current owner, zero when idle
//   timeout_err  one-cycle pulse when a grant is force-released
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int data_bits = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*data_bits-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]           req_tvalid,
  input  logic [NUM_REQ-1:0]           req_tlast,
  output logic [NUM_REQ-1:0]           req_tready,
  output logic [data_bits-1:0]         m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] LAST_OWNER_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT - 1);

`ifdef ARB_ID_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic                 owner_vld;
  logic                 owner_last;
  logic [data_bits-1:0] owner_data;

  // Round-robin search. Scanning from the farthest candidate down to the
  // nearest one lets the nearest valid requester after last_owner win by
  // being assigned last.
  always_comb begin
    win_idx = last_owner_q;
    win_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_tvalid[(int'(last_owner_q) + k) % NUM_REQ]) begin
        win_idx = IDX_W'((int'(last_owner_q) + k) % NUM_REQ);
        win_vld = 1'b1;
      end
    end
  end

  assign owner_vld  = req_tvalid[owner_q];
  assign owner_last = req_tlast[owner_q];
  assign owner_data = req_tdata[owner_q*data_bits +: data_bits];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    grant        = '0;
    req_tready   = '0;
    m_tdata      = '0;
    m_tvalid     = 1'b0;
    timeout_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (win_vld) begin
          owner_d = win_idx;
`ifdef ARB_ID_EN
          state_d = ST_HDR;
`else
          state_d = ST_DATA;
`endif
        end
      end

`ifdef ARB_ID_EN
      // Header byte is generated locally; no requester byte is consumed.
      ST_HDR: begin
        grant[owner_q] = 1'b1;
        m_tdata        = data_bits'(owner_q);
        m_tvalid       = 1'b1;
        if (m_tready) begin
          state_d = ST_DATA;
        end
      end
`endif

      ST_DATA: begin
        grant[owner_q]      = 1'b1;
        m_tdata             = owner_data;
        m_tvalid            = owner_vld;
        req_tready[owner_q] = m_tready;
        // A valid owner byte (accepted or back-pressured) is activity, so
        // the idle run only grows on cycles where the owner offers nothing.
        if (owner_vld) begin
          idle_cnt_d = '0;
          if (m_tready && owner_last) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
          end
        end else if (idle_cnt_q == CNT_LAST) begin
          timeout_err  = 1'b1;
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          idle_cnt_d   = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_OWNER_RST;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmit stream (2..8).
REQ-002 The block SHALL have parameter data_bits, default 8: byte width, matching the UART data_in width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: number of consecutive idle cycles within a packet before the grant is forcibly released (>=2).
REQ-004 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_tdata, input, NUM_REQ*data_bits: requester bytes; requester i occupies bits [i*data_bits +: data_bits].
REQ-007 The block SHALL have ports req_tvalid, req_tlast (input, NUM_REQ) and req_tready (output, NUM_REQ): the per-requester handshake, with last marking the final byte of a packet.
REQ-008 The block SHALL have ports m_tdata (output, data_bits), m_tvalid (output, 1) and m_tready (input, 1): the stream to the UART data_in / data_in_valid / data_in_ready.
REQ-009 The block SHALL have port grant, output, NUM_REQ: one-hot current owner, all zero when idle.
REQ-010 The block SHALL have port timeout_err, output, 1: a one-cycle pulse when a grant is force-released.

Function
REQ-011 The FSM SHALL have the states IDLE, HDR (present only with ARB_ID_EN) and DATA.
REQ-012 IDLE: when any req_tvalid is high, the block SHALL register a round-robin winner, searching from index (last_owner+1) mod NUM_REQ upward with wrap-around, and then go to HDR or DATA.
REQ-013 The grant SHALL change only in IDLE and SHALL be held until packet end, so bytes from different requesters never interleave.
REQ-014 In DATA the path SHALL be combinational: m_tdata and m_tvalid equal the owner's req_tdata and req_tvalid, req_tready[owner] equals m_tready, and every other req_tready is 0.
REQ-015 A handshake with req_tlast[owner]=1 SHALL return the block to IDLE on the next cycle and set last_owner to owner; a single-byte packet is legal.
REQ-016 Arbitration latency SHALL be one cycle from request to grant, and there SHALL be exactly one bubble cycle in IDLE between consecutive packets.
REQ-017 In DATA, when req_tvalid[owner] stays low for TIMEOUT consecutive cycles, the block SHALL pulse timeout_err, return to IDLE and update last_owner; the idle counter SHALL clear on any owner-valid cycle.
REQ-018 The idle counter SHALL not run while m_tvalid=1 and m_tready=0 (back-pressure is not a timeout).
REQ-019 In IDLE, m_tvalid SHALL be 0 and all req_tready SHALL be 0.
REQ-020 Once asserted, m_tvalid SHALL not drop before its handshake, provided the requester obeys the same rule.

Reset
REQ-021 On rst=1 at a clock edge the block SHALL enter IDLE with grant=0, m_tvalid=0, m_tdata=0, req_tready=0, timeout_err=0, idle counter=0 and last_owner=NUM_REQ-1 (requester 0 has first priority).
REQ-022 Reset mid-packet SHALL drop the grant immediately; bytes already handed to the UART are not recalled.

Configuration
REQ-023 With macro ARB_ID_EN defined, each packet SHALL be preceded by one header byte in state HDR: m_tdata equals the owner index zero-extended to data_bits, m_tvalid=1, req_tready all 0, and the FSM moves to DATA on the handshake.
REQ-024 Without ARB_ID_EN, the HDR state and its logic SHALL be absent and IDLE SHALL go directly to DATA.

Verification
REQ-025 Bench: req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), m_tready=1 -> the same 3 bytes appear on m_tdata in order, grant=0001, then IDLE.
REQ-026 Bench: req0..req3 all valid with 2-byte packets -> packet order 0,1,2,3,0, with one bubble between packets and no interleaving.
REQ-027 Bench: req1 mid-packet while req2 requests and m_tready toggles 1,0,0,1 -> req1's packet completes intact before grant=0100, with no byte lost or duplicated.
REQ-028 Bench: TIMEOUT=16, req3 sends 1 byte without last and then drops valid -> timeout_err pulses on idle cycle 16, grant becomes 0, and a pending req0 is granted next.
REQ-029 Bench: ARB_ID_EN defined, req2 sends 0xA5 (last) -> m_tdata sequence 0x02, 0xA5.
REQ-030 Bench: rst pulsed during byte 2 of a 4-byte req1 packet -> the next cycle shows grant=0 and m_tvalid=0, then req0 wins if both request.
